s420_match_sequencer: RTL and testbench
=======================================

# s420_match_sequencer

Upstream controller for the s420 counter/comparator core. It accepts a 17-bit compare code from a host over a valid/ready handshake and drives that code onto the core's C_0..C_16 inputs. It then holds the core's count enable P_0 high until the core's match output Z is sampled high, or until a cycle limit expires. It returns one result per command: the number of enabled cycles and a timeout flag, over a second valid/ready handshake.

## Interface
Parameters:
- TIMEOUT, default 65535: maximum RUN cycles per command. Legal range 1..65535.

Ports:
- CK  input  1  clock; all flops update on the rising edge.
- RN  input  1  reset, asynchronous, active-low.
- CMD_VALID  input  1  host offers a command.
- CMD_READY  output  1  block accepts a command; high only in IDLE.
- CMD_CODE  input  17  compare code; bit k drives C_k.
- CMD_ABORT  input  1  cancels an in-flight command in SETTLE or RUN.
- C  output  17  registered compare code to the core; C[k] connects to C_k.
- P_0  output  1  registered count enable to the core.
- Z  input  1  match output from the core; combinational there, sampled here.
- RES_VALID  output  1  a result is available.
- RES_READY  input  1  host takes the result.
- RES_CYCLES  output  16  number of RUN cycles used.
- RES_TIMEOUT  output  1  1 means no match occurred within TIMEOUT cycles.

## Operation
- The FSM has four states: IDLE, SETTLE, RUN and DONE. Encoding is free. All outputs are registered.
- IDLE:
  - CMD_READY=1, P_0=0, RES_VALID=0. C holds the last loaded code.
  - When CMD_VALID=1 at an edge, CMD_CODE loads into C, cnt clears to 0, and the FSM moves to SETTLE.
- SETTLE:
  - Lasts exactly one cycle. P_0 stays 0 so the core's comparator sees the new code before counting starts.
  - Next state is RUN.
- RUN:
  - P_0=1 and cnt increments by 1 at each edge.
  - At each edge, Z is sampled:
    - If Z=1: RES_CYCLES is loaded with cnt+1, RES_TIMEOUT=0, and the FSM moves to DONE.
    - Else if cnt+1 equals TIMEOUT: RES_CYCLES is loaded with TIMEOUT, RES_TIMEOUT=1, and the FSM moves to DONE.
- DONE:
  - P_0=0, RES_VALID=1. RES_CYCLES and RES_TIMEOUT are held stable.
  - C is held.
  - When RES_READY=1 at an edge, the FSM moves to IDLE.
- Abort:
  - CMD_ABORT=1 at an edge in SETTLE or RUN sends the FSM to IDLE. P_0 goes to 0 and no result is produced.
  - CMD_ABORT is ignored in IDLE and DONE.
- Arithmetic: cnt is 16 bits unsigned. Because TIMEOUT ≤ 65535, cnt never wraps.
- Z is ignored in every state other than RUN.

## Timing
- Reset (RN=0) forces these values immediately and asynchronously: state=IDLE, C=0, P_0=0, CMD_READY=0, RES_VALID=0, RES_CYCLES=0, RES_TIMEOUT=0, cnt=0.
- CMD_READY rises at the first CK edge after RN deasserts. It is never high during reset.
- Command latency:
  - Accept edge T: C is valid after T.
  - SETTLE occupies T..T+1.
  - P_0 rises after edge T+1.
  - The first Z sample is at edge T+2.
- Match at RUN edge n (n=1 is the first RUN edge): RES_CYCLES=n. RES_VALID and P_0=0 are both visible right after that edge, so no extra P_0 cycle is issued.
- Simultaneous events:
  - Z=1 on the TIMEOUT edge: the match wins, RES_TIMEOUT=0 and RES_CYCLES=TIMEOUT.
  - CMD_ABORT together with Z=1 or timeout: the abort wins and no result is produced.
- Back-to-back commands: RES_READY accepted at edge D means the next CMD_VALID can be accepted at edge D+1 at the earliest. CMD_READY is 0 throughout DONE.
- Reset asserted mid-RUN: P_0 drops asynchronously and the result is discarded.

## Test plan
- Reset, then CMD_CODE=17'h00005 with Z modelled to go high on the 5th enabled cycle:
  - CMD_READY=1 one edge after RN release.
  - P_0 high for exactly 5 cycles starting 2 edges after accept.
  - RES_VALID with RES_CYCLES=5, RES_TIMEOUT=0.
- TIMEOUT=8, Z held 0: P_0 high for exactly 8 cycles, then RES_CYCLES=8, RES_TIMEOUT=1.
- TIMEOUT=8, Z=1 only on the 8th RUN edge: RES_CYCLES=8, RES_TIMEOUT=0 (match beats timeout).
- CMD_ABORT at RUN cycle 3:
  - P_0 falls after that edge.
  - RES_VALID never rises.
  - CMD_READY=1 on the next cycle; a following command completes normally.
- RES_READY held 0 for 10 cycles in DONE:
  - RES_VALID, RES_CYCLES, RES_TIMEOUT and C remain stable.
  - CMD_VALID=1 during DONE is not accepted.
  - The command is accepted at the edge after RES_READY.
- RN pulsed low for half a cycle mid-RUN: all outputs reach their reset values immediately without waiting for CK; operation resumes cleanly after release.

Source files
------------

// File: rtl/s420_match_sequencer_if.sv
// Host command/result handshakes plus the compare-code, count-enable and match
// lines to the s420 core, bundled for the match sequencer.
interface s420_match_sequencer_if;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [16:0] CMD_CODE;
  logic        CMD_ABORT;
  logic [16:0] C;
  logic        P_0;
  logic        Z;
  logic        RES_VALID;
  logic        RES_READY;
  logic [15:0] RES_CYCLES;
  logic        RES_TIMEOUT;

  modport slave (
    input  CMD_VALID, CMD_CODE, CMD_ABORT, Z, RES_READY,
    output CMD_READY, C, P_0, RES_VALID, RES_CYCLES, RES_TIMEOUT
  );

  modport master (
    output CMD_VALID, CMD_CODE, CMD_ABORT, Z, RES_READY,
    input  CMD_READY, C, P_0, RES_VALID, RES_CYCLES, RES_TIMEOUT
  );
endinterface

// File: rtl/s420_match_sequencer.sv
// Loads a compare code, settles one cycle, then counts with P_0 until Z or TIMEOUT.
// P_0 rises two edges after accept; one result per command, held until RES_READY.
module s420_match_sequencer #(
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic                  CK,
  input  logic                  RN,
  s420_match_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, RUN, DONE} state_e;

  localparam logic [16:0] TMO = 17'(TIMEOUT);

  state_e      state_q, state_d;
  logic [16:0] c_q, c_d;
  logic [15:0] cnt_q, cnt_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        p0_q, p0_d;
  logic        res_valid_q, res_valid_d;
  logic [15:0] res_cycles_q, res_cycles_d;
  logic        res_timeout_q, res_timeout_d;
  logic [16:0] cnt_inc;

  assign cnt_inc = {1'b0, cnt_q} + 17'd1;

  always_comb begin
    state_d       = state_q;
    c_d           = c_q;
    cnt_d         = cnt_q;
    res_cycles_d  = res_cycles_q;
    res_timeout_d = res_timeout_q;

    case (state_q)
      IDLE: begin
        // cmd_ready_q gates acceptance so nothing is taken on the first edge out of reset
        if (cmd_ready_q && bus.CMD_VALID) begin
          c_d     = bus.CMD_CODE;
          cnt_d   = 16'd0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        state_d = bus.CMD_ABORT ? IDLE : RUN;
      end
      RUN: begin
        if (bus.CMD_ABORT) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc[15:0];
          if (bus.Z) begin
            res_cycles_d  = cnt_inc[15:0];
            res_timeout_d = 1'b0;
            state_d       = DONE;
          end else if (cnt_inc == TMO) begin
            res_cycles_d  = cnt_inc[15:0];
            res_timeout_d = 1'b1;
            state_d       = DONE;
          end
        end
      end
      DONE: begin
        if (bus.RES_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Registered outputs are decoded from the next state so they track it edge for edge.
    cmd_ready_d = (state_d == IDLE);
    p0_d        = (state_d == RUN);
    res_valid_d = (state_d == DONE);
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q       <= IDLE;
      c_q           <= '0;
      cnt_q         <= '0;
      cmd_ready_q   <= 1'b0;
      p0_q          <= 1'b0;
      res_valid_q   <= 1'b0;
      res_cycles_q  <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      c_q           <= c_d;
      cnt_q         <= cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      p0_q          <= p0_d;
      res_valid_q   <= res_valid_d;
      res_cycles_q  <= res_cycles_d;
      res_timeout_q <= res_timeout_d;
    end
  end

  assign bus.CMD_READY   = cmd_ready_q;
  assign bus.C           = c_q;
  assign bus.P_0         = p0_q;
  assign bus.RES_VALID   = res_valid_q;
  assign bus.RES_CYCLES  = res_cycles_q;
  assign bus.RES_TIMEOUT = res_timeout_q;

endmodule

// File: tb/tb_s420_match_sequencer.sv
// Randomized bench for s420_match_sequencer against a per-command outcome model.
module tb_s420_match_sequencer;
  localparam int TMO = 8;

  logic CK = 1'b0;
  logic RN = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  s420_match_sequencer_if bus();

  s420_match_sequencer #(.TIMEOUT(TMO)) dut (
    .CK  (CK),
    .RN  (RN),
    .bus (bus)
  );

  always #5 CK = ~CK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  // Outcome of one command from the rules: m = RUN cycle where Z is high (0 = never),
  // a = RUN cycle carrying CMD_ABORT (0 = during SETTLE, -1 = none).
  task automatic model(input int m, input int a, output bit ab, output int p0,
                       output int cyc, output bit to);
    int fin;
    bit hit;
    hit = (m >= 1) && (m <= TMO);
    fin = hit ? m : TMO;
    cyc = 0;
    to  = 0;
    if (a >= 0 && a <= fin) begin
      ab = 1;
      p0 = a;
    end else begin
      ab  = 0;
      p0  = fin;
      cyc = fin;
      to  = !hit;
    end
  endtask

  task automatic run_cmd(input logic [16:0] code, input int m, input int a, input int hold);
    bit   exp_ab, exp_to, got_ab, got_res, first;
    int   exp_p0, exp_cyc, p0cnt, waited;
    logic [15:0] cyc_s;
    logic        to_s;
    model(m, a, exp_ab, exp_p0, exp_cyc, exp_to);

    waited = 0;
    while (!bus.CMD_READY && waited < 50) begin
      @(negedge CK);
      waited++;
    end
    if (!bus.CMD_READY) check_val("ready_wait_bound", 0, 1);

    bus.CMD_VALID = 1'b1;
    bus.CMD_CODE  = code;
    @(negedge CK);
    bus.CMD_VALID = 1'b0;
    bus.CMD_CODE  = $urandom;
    check_val("settle_ready", bus.CMD_READY, 0);
    check_val("settle_p0", bus.P_0, 0);
    check_val("load_c", bus.C, code);
    bus.Z         = $urandom;
    bus.CMD_ABORT = (a == 0);

    p0cnt   = 0;
    got_ab  = 0;
    got_res = 0;
    first   = 1;
    for (int i = 0; i < 100 && !got_ab && !got_res; i++) begin
      @(negedge CK);
      if (first) begin
        check_val("p0_start", bus.P_0, exp_p0 > 0);
        first = 0;
      end
      if (bus.RES_VALID) begin
        got_res = 1;
      end else if (bus.CMD_READY) begin
        got_ab = 1;
      end else if (bus.P_0) begin
        p0cnt++;
        bus.Z         = (p0cnt == m);
        bus.CMD_ABORT = (p0cnt == a);
      end else begin
        bus.Z         = $urandom;
        bus.CMD_ABORT = 1'b0;
      end
    end
    bus.CMD_ABORT = 1'b0;
    bus.Z         = $urandom;
    if (!got_ab && !got_res) check_val("run_bound", 0, 1);

    check_val("aborted", got_ab, exp_ab);
    check_val("p0_cycles", p0cnt, exp_p0);
    check_val("end_p0_low", bus.P_0, 0);
    if (got_res) begin
      check_val("res_cycles", bus.RES_CYCLES, exp_cyc);
      check_val("res_timeout", bus.RES_TIMEOUT, exp_to);
      cyc_s = bus.RES_CYCLES;
      to_s  = bus.RES_TIMEOUT;
      bus.RES_READY = 1'b0;
      for (int i = 0; i < hold; i++) begin
        bus.CMD_VALID = 1'b1;
        bus.CMD_CODE  = ~code;
        bus.Z         = $urandom;
        bus.CMD_ABORT = $urandom;
        @(negedge CK);
      end
      bus.CMD_VALID = 1'b0;
      bus.CMD_ABORT = 1'b0;
      if (hold > 0) begin
        check_val("hold_valid", bus.RES_VALID, 1);
        check_val("hold_cycles", bus.RES_CYCLES, cyc_s);
        check_val("hold_timeout", bus.RES_TIMEOUT, to_s);
        check_val("hold_c", bus.C, code);
        check_val("hold_ready", bus.CMD_READY, 0);
      end
      bus.RES_READY = 1'b1;
      @(negedge CK);
      bus.RES_READY = 1'b0;
      check_val("drain_valid", bus.RES_VALID, 0);
      check_val("drain_ready", bus.CMD_READY, 1);
    end else begin
      check_val("abort_no_result", bus.RES_VALID, 0);
      check_val("abort_ready", bus.CMD_READY, 1);
    end
  endtask

  initial begin
    int m, a;
    bus.CMD_VALID = 1'b0;
    bus.CMD_CODE  = '0;
    bus.CMD_ABORT = 1'b0;
    bus.Z         = 1'b0;
    bus.RES_READY = 1'b0;

    #1;
    check_val("rst_ready", bus.CMD_READY, 0);
    check_val("rst_p0", bus.P_0, 0);
    check_val("rst_c", bus.C, 0);
    check_val("rst_valid", bus.RES_VALID, 0);
    bus.CMD_VALID = 1'b1;
    repeat (3) @(negedge CK);
    RN = 1'b1;
    #1;
    check_val("rel_ready_low", bus.CMD_READY, 0);
    @(negedge CK);
    check_val("rel_ready_high", bus.CMD_READY, 1);
    check_val("rel_no_accept", bus.C, 0);
    bus.CMD_VALID = 1'b0;

    run_cmd(17'h00005, 5, -1, 0);
    run_cmd(17'h1abcd, 0, -1, 0);
    run_cmd(17'h0f0f0, 8, -1, 0);
    run_cmd(17'h12345, 0, 3, 0);
    run_cmd(17'h00777, 2, -1, 0);
    run_cmd(17'h1ffff, 6, -1, 10);
    run_cmd(17'h00a5a, 4, 0, 0);
    run_cmd(17'h05a5a, 4, 4, 0);
    run_cmd(17'h13579, 0, 8, 0);
    run_cmd(17'h00001, 1, -1, 2);

    for (int t = 0; t < 25; t++) begin
      m = $urandom_range(0, 10);
      a = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 9) : -1;
      run_cmd(17'($urandom), m, a, $urandom_range(0, 3));
    end

    // Asynchronous reset in the middle of RUN
    while (!bus.CMD_READY) @(negedge CK);
    bus.CMD_VALID = 1'b1;
    bus.CMD_CODE  = 17'h0beef;
    bus.Z         = 1'b0;
    @(negedge CK);
    bus.CMD_VALID = 1'b0;
    repeat (3) @(negedge CK);
    check_val("pre_rst_p0", bus.P_0, 1);
    @(posedge CK);
    #2;
    RN = 1'b0;
    #1;
    check_val("arst_p0", bus.P_0, 0);
    check_val("arst_c", bus.C, 0);
    check_val("arst_ready", bus.CMD_READY, 0);
    check_val("arst_valid", bus.RES_VALID, 0);
    check_val("arst_cycles", bus.RES_CYCLES, 0);
    check_val("arst_timeout", bus.RES_TIMEOUT, 0);
    @(negedge CK);
    RN = 1'b1;
    @(negedge CK);
    check_val("arst_resume_ready", bus.CMD_READY, 1);
    check_val("arst_resume_p0", bus.P_0, 0);
    run_cmd(17'h00321, 3, -1, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
